ysyx_24090018_axi_rd_slave: RTL
===============================

YSYX_24090018_AXI_RD_SLAVE -- requirements
Module: ysyx_24090018_axi_rd_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width.
REQ-002 SHALL have parameter DATA_W, default 32: data width.
REQ-003 SHALL have parameter BASE, default 32'h8000_0000: lowest legal address.
REQ-004 SHALL have parameter SIZE, default 32'h0800_0000: legal window size in bytes.
REQ-005 SHALL have parameter LFSR_SEED, default 8'hA5: delay LFSR reset value, nonzero.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port araddr_i, input, ADDR_W bits: read address.
REQ-009 SHALL have port arvalid_i, input, 1 bit: address valid.
REQ-010 SHALL have port arready_o, output, 1 bit: address accepted.
REQ-011 SHALL have port rdata_o, output, DATA_W bits: read data.
REQ-012 SHALL have port rresp_o, output, 2 bits: 00 OKAY, 10 SLVERR, 11 DECERR.
REQ-013 SHALL have port rvalid_o, output, 1 bit: response valid.
REQ-014 SHALL have port rready_i, input, 1 bit: master accepts response.
REQ-015 SHALL have port mem_ren_o, output, 1 bit: backing-memory read strobe.
REQ-016 SHALL have port mem_addr_o, output, ADDR_W bits: backing-memory address.
REQ-017 SHALL have port mem_rdata_i, input, DATA_W bits: memory data, valid exactly one cycle after mem_ren_o.

Function
REQ-018 SHALL implement FSM states IDLE, DELAY, ISSUE, CAPT, RESP; one outstanding read maximum.
REQ-019 SHALL drive arready_o=1 only in IDLE; AR handshake = arvalid_i & arready_o at a rising edge; araddr_i latched then.
REQ-020 SHALL, on handshake with araddr_i[1:0]!=0, go to RESP with rresp_o=10, rdata_o=0, no mem_ren_o pulse.
REQ-021 SHALL, on aligned handshake with araddr_i outside [BASE, BASE+SIZE), go to RESP with rresp_o=11, rdata_o=0, no mem_ren_o pulse; misalignment takes priority over range.
REQ-022 SHALL, on legal handshake, go to ISSUE (or DELAY per REQ-034).
REQ-023 SHALL assert mem_ren_o for exactly one cycle in ISSUE with mem_addr_o = latched address; mem_ren_o=0 in all other states; mem_addr_o holds latched address otherwise.
REQ-024 SHALL in CAPT register mem_rdata_i into rdata_o, set rresp_o=00, advance to RESP.
REQ-025 SHALL assert rvalid_o only in RESP; rdata_o and rresp_o stable while rvalid_o=1 and rready_i=0.
REQ-026 SHALL return to IDLE on R handshake (rvalid_o & rready_i); arready_o=1 the following cycle.
REQ-027 SHALL give latency, handshake edge to rvalid_o high: 3 cycles for OKAY path (no delay), 1 cycle for error paths.
REQ-028 SHALL ignore arvalid_i outside IDLE (no latch, no state change).
REQ-029 SHALL tolerate rready_i held high before rvalid_o; response completes in first RESP cycle.
REQ-030 SHALL compute range check without overflow (ADDR_W+1-bit arithmetic for BASE+SIZE).

Reset
REQ-031 SHALL, on rst low, asynchronously force IDLE, arready_o=0 while rst low, rvalid_o=0, mem_ren_o=0, rdata_o=0, rresp_o=00, mem_addr_o=0, LFSR=LFSR_SEED.
REQ-032 SHALL discard any in-flight read on reset; no response issued for it after rst release.
REQ-033 SHALL drive arready_o=1 in the first cycle after rst deasserts.

Configuration
REQ-034 SHALL, with macro YSYX_24090018_RDELAY_EN defined, run an 8-bit Fibonacci LFSR (taps 8,6,5,4) stepping every cycle; on legal handshake load delay=LFSR[2:0]; if nonzero enter DELAY for that many cycles then ISSUE, else ISSUE directly; OKAY latency 3..10 cycles.
REQ-035 SHALL, without YSYX_24090018_RDELAY_EN, contain no LFSR, never enter DELAY, fixed OKAY latency 3 cycles.

Verification
REQ-036 SHALL cover: after reset, araddr_i=8000_0010, mem_rdata_i=DEADBEEF -> one mem_ren_o pulse, mem_addr_o=8000_0010, rvalid_o 3 cycles after handshake, rdata_o=DEADBEEF, rresp_o=00.
REQ-037 SHALL cover: araddr_i=8000_0002 -> rvalid_o after 1 cycle, rresp_o=10, rdata_o=0, no mem_ren_o.
REQ-038 SHALL cover: araddr_i=8800_0000 and 7FFF_FFFC -> rresp_o=11, no mem_ren_o.
REQ-039 SHALL cover: rready_i low 5 cycles during RESP -> rvalid_o, rdata_o, rresp_o constant; arvalid_i pulsed meanwhile ignored, arready_o=0.
REQ-040 SHALL cover: rst pulsed low in CAPT -> rvalid_o=0 immediately, no response after release, next read OKAY.
REQ-041 SHALL cover, with YSYX_24090018_RDELAY_EN: 100 back-to-back reads -> every latency in 3..10, data correct, at least two distinct latencies.

Source files
------------

// File: rtl/ysyx_24090018_axi_rd_slave.sv
// AXI-lite style read slave: one outstanding read, address window/alignment checks, backing-memory fetch.
// Optional random response delay enabled by defining YSYX_24090018_RDELAY_EN.
module ysyx_24090018_axi_rd_slave #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE      = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] SIZE      = 32'h0800_0000,
    parameter logic [7:0]        LFSR_SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] araddr_i,
    input  logic              arvalid_i,
    output logic              arready_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [1:0]        rresp_o,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic              mem_ren_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Window bounds carry one extra bit so BASE+SIZE cannot wrap.
    localparam logic [ADDR_W:0] WIN_LO = {1'b0, BASE};
    localparam logic [ADDR_W:0] WIN_HI = WIN_LO + {1'b0, SIZE};

    if (LFSR_SEED == 8'h00) begin : g_seed_chk
        $error("LFSR_SEED must be nonzero");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DELAY = 3'd1,
        ISSUE = 3'd2,
        CAPT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                arready_d, rvalid_d, mem_ren_d;
    logic [DATA_W-1:0]   rdata_d;
    logic [1:0]          rresp_d;
    logic [ADDR_W-1:0]   addr_d;
    logic                ar_hs, misaligned, in_window;
    logic [ADDR_W:0]     addr_ext;

    assign ar_hs      = arvalid_i & arready_o;
    assign addr_ext   = {1'b0, araddr_i};
    assign misaligned = (araddr_i[1:0] != 2'b00);
    assign in_window  = (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);

`ifdef YSYX_24090018_RDELAY_EN
    logic [7:0] lfsr_q;
    logic [2:0] cnt_q, cnt_d;

    // Fibonacci LFSR, taps 8,6,5,4, free-running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= LFSR_SEED;
            cnt_q  <= 3'd0;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            cnt_q  <= cnt_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
        mem_ren_d = 1'b0;
        rdata_d   = rdata_o;
        rresp_d   = rresp_o;
        addr_d    = mem_addr_o;
`ifdef YSYX_24090018_RDELAY_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (ar_hs) begin
                    addr_d = araddr_i;
                    if (misaligned) begin
                        state_d = RESP;
                        rresp_d = RESP_SLVERR;
                        rdata_d = '0;
                    end else if (!in_window) begin
                        state_d = RESP;
                        rresp_d = RESP_DECERR;
                        rdata_d = '0;
                    end else begin
`ifdef YSYX_24090018_RDELAY_EN
                        cnt_d   = lfsr_q[2:0];
                        state_d = (lfsr_q[2:0] != 3'd0) ? DELAY : ISSUE;
`else
                        state_d = ISSUE;
`endif
                    end
                end
            end
            DELAY: begin
`ifdef YSYX_24090018_RDELAY_EN
                if (cnt_q <= 3'd1) state_d = ISSUE;
                else               cnt_d   = cnt_q - 3'd1;
`else
                state_d = ISSUE;
`endif
            end
            ISSUE: state_d = CAPT;
            CAPT: begin
                rdata_d = mem_rdata_i;
                rresp_d = RESP_OKAY;
                state_d = RESP;
            end
            RESP: begin
                if (rvalid_o && rready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Handshake flags are registered copies of the next state.
        arready_d = (state_d == IDLE);
        rvalid_d  = (state_d == RESP);
        mem_ren_d = (state_d == ISSUE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            arready_o  <= 1'b0;
            rvalid_o   <= 1'b0;
            mem_ren_o  <= 1'b0;
            rdata_o    <= '0;
            rresp_o    <= RESP_OKAY;
            mem_addr_o <= '0;
        end else begin
            state_q    <= state_d;
            arready_o  <= arready_d;
            rvalid_o   <= rvalid_d;
            mem_ren_o  <= mem_ren_d;
            rdata_o    <= rdata_d;
            rresp_o    <= rresp_d;
            mem_addr_o <= addr_d;
        end
    end

endmodule
